// File: rtl/seq_adder_if.sv
// Handshake and operand/result bundle for the multi-cycle adder/subtractor.
interface seq_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, sub, Ain, Bin,
        input  S, Cout, Ovf, busy, done
    );

    modport slave (
        input  start, sub, Ain, Bin,
        output S, Cout, Ovf, busy, done
    );
endinterface

// File: rtl/seq_adder.sv
// Multi-cycle two's-complement adder/subtractor: STEP bits per clock, LSB first,
// with carry-out and signed-overflow reporting and a start/busy/done handshake.
module seq_adder #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic        clk,
    input  logic        rst,
    seq_adder_if.slave  bus
);
    localparam int NSTEPS = WIDTH / STEP;
    localparam int CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [STEP:0]        sum_ext_s;
    logic                 carry_msb_s;
    logic [WIDTH+STEP-1:0] res_cat_s;
    logic [WIDTH-1:0]     res_shift_s;

    // One STEP-wide slice addition plus the carry into the slice's top bit.
    always_comb begin
        sum_ext_s   = {1'b0, a_q[STEP-1:0]} + {1'b0, b_q[STEP-1:0]}
                    + {{STEP{1'b0}}, carry_q};
        // Carry into the top bit is recovered from its sum bit and operand bits.
        carry_msb_s = sum_ext_s[STEP-1] ^ a_q[STEP-1] ^ b_q[STEP-1];
        // New slice enters at the top; previous partial result moves down.
        res_cat_s   = {sum_ext_s[STEP-1:0], res_q} >> STEP;
        res_shift_s = res_cat_s[WIDTH-1:0];
    end

    // Next-state, datapath updates and registered-output next values.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    a_d     = bus.Ain;
                    b_d     = bus.sub ? ~bus.Bin : bus.Bin;
                    carry_d = bus.sub;
                    res_d   = {WIDTH{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> STEP;
                b_d     = b_q >> STEP;
                res_d   = res_shift_s;
                carry_d = sum_ext_s[STEP];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    s_d     = res_shift_s;
                    cout_d  = sum_ext_s[STEP];
                    ovf_d   = carry_msb_s ^ sum_ext_s[STEP];
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            s_q     <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.S    = s_q;
    assign bus.Cout = cout_q;
    assign bus.Ovf  = ovf_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_seq_adder.sv
// Directed bench for seq_adder: one 8-bit/1-step instance and one 8-bit/4-step instance.
module tb_seq_adder;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    seq_adder_if #(.WIDTH(8)) bus1();
    seq_adder_if #(.WIDTH(8)) bus4();

    seq_adder #(.WIDTH(8), .STEP(1)) u_s1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    seq_adder #(.WIDTH(8), .STEP(4)) u_s4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one op on the STEP=1 instance and check busy window, done and result.
    task automatic run_op1(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic [7:0] es, input logic ec, input logic ev);
        bus1.Ain = a; bus1.Bin = b; bus1.sub = s; bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0; bus1.Ain = 8'h00; bus1.Bin = 8'h00; bus1.sub = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_busy"}, 32'(bus1.busy), 32'd1);
            chk({tag, "_nodone"}, 32'(bus1.done), 32'd0);
            tick();
        end
        chk({tag, "_done"}, 32'(bus1.done), 32'd1);
        chk({tag, "_idle"}, 32'(bus1.busy), 32'd0);
        chk({tag, "_S"}, 32'(bus1.S), 32'(es));
        chk({tag, "_Cout"}, 32'(bus1.Cout), 32'(ec));
        chk({tag, "_Ovf"}, 32'(bus1.Ovf), 32'(ev));
        tick();
        chk({tag, "_pulse"}, 32'(bus1.done), 32'd0);
        chk({tag, "_hold"}, 32'(bus1.S), 32'(es));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus1.start = 1'b0; bus1.sub = 1'b0; bus1.Ain = 8'h00; bus1.Bin = 8'h00;
        bus4.start = 1'b0; bus4.sub = 1'b0; bus4.Ain = 8'h00; bus4.Bin = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_S", 32'(bus1.S), 32'h00);
        chk("rst_Cout", 32'(bus1.Cout), 32'd0);
        chk("rst_Ovf", 32'(bus1.Ovf), 32'd0);
        chk("rst_busy", 32'(bus1.busy), 32'd0);
        chk("rst_done", 32'(bus1.done), 32'd0);
        tick();

        // Arithmetic vectors
        run_op1("add", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        run_op1("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op1("sovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op1("sub_borrow", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op1("sub_ovf", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // start and operand changes during RUN are ignored
        bus1.Ain = 8'h12; bus1.Bin = 8'h34; bus1.sub = 1'b0; bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        tick(); tick(); tick();
        bus1.start = 1'b1; bus1.Ain = 8'hFF; bus1.Bin = 8'hFF; bus1.sub = 1'b1;
        tick();
        bus1.start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("midrun_done", 32'(bus1.done), 32'd1);
        chk("midrun_S", 32'(bus1.S), 32'h46);
        chk("midrun_Cout", 32'(bus1.Cout), 32'd0);
        tick();
        chk("midrun_idle", 32'(bus1.busy), 32'd0);

        // Back-to-back: start held through DONE relaunches without an IDLE cycle
        bus1.Ain = 8'h01; bus1.Bin = 8'h02; bus1.sub = 1'b0; bus1.start = 1'b1;
        tick();
        bus1.Ain = 8'h05; bus1.Bin = 8'h06;
        for (int i = 0; i < 8; i++) tick();
        chk("b2b_done1", 32'(bus1.done), 32'd1);
        chk("b2b_S1", 32'(bus1.S), 32'h03);
        tick();
        bus1.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_busy2", 32'(bus1.busy), 32'd1);
            chk("b2b_Sstable", 32'(bus1.S), 32'h03);
            tick();
        end
        chk("b2b_done2", 32'(bus1.done), 32'd1);
        chk("b2b_S2", 32'(bus1.S), 32'h0B);
        tick();

        // Reset mid-operation aborts with no done pulse
        bus1.Ain = 8'hAA; bus1.Bin = 8'h11; bus1.sub = 1'b0; bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(bus1.busy), 32'd0);
        chk("abort_S", 32'(bus1.S), 32'h00);
        for (int i = 0; i < 10; i++) begin
            chk("abort_nodone", 32'(bus1.done), 32'd0);
            tick();
        end
        run_op1("after_abort", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);

        // STEP=4: two slices, done three cycles after the start edge
        bus4.Ain = 8'h9C; bus4.Bin = 8'h6B; bus4.sub = 1'b0; bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0; bus4.Ain = 8'h00; bus4.Bin = 8'h00;
        chk("s4_busy1", 32'(bus4.busy), 32'd1);
        chk("s4_S_hold", 32'(bus4.S), 32'h00);
        tick();
        chk("s4_busy2", 32'(bus4.busy), 32'd1);
        chk("s4_nodone", 32'(bus4.done), 32'd0);
        tick();
        chk("s4_done", 32'(bus4.done), 32'd1);
        chk("s4_S", 32'(bus4.S), 32'h07);
        chk("s4_Cout", 32'(bus4.Cout), 32'd1);
        chk("s4_Ovf", 32'(bus4.Ovf), 32'd0);
        tick();
        chk("s4_pulse", 32'(bus4.done), 32'd0);

        // STEP=4 signed overflow through the in-slice carry into the MSB
        bus4.Ain = 8'h7F; bus4.Bin = 8'h01; bus4.sub = 1'b0; bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        tick(); tick();
        chk("s4ovf_S", 32'(bus4.S), 32'h80);
        chk("s4ovf_Cout", 32'(bus4.Cout), 32'd0);
        chk("s4ovf_Ovf", 32'(bus4.Ovf), 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
